// File: rtl/sq_pkg.sv
// Shared widths and the 4-bit squaring table used by the signed squarer.
package sq_pkg;

    localparam int SQ_IN_W  = 8;
    localparam int SQ_OUT_W = 15;
    localparam int SQ_NIB_W = 4;
    localparam int SQ_NSQ_W = 8;

    function automatic logic [SQ_NSQ_W-1:0] nib_sq(
        input logic [SQ_NIB_W-1:0] n
    );
        logic [SQ_NSQ_W-1:0] r;
        case (n)
            4'd0:    r = 8'd0;
            4'd1:    r = 8'd1;
            4'd2:    r = 8'd4;
            4'd3:    r = 8'd9;
            4'd4:    r = 8'd16;
            4'd5:    r = 8'd25;
            4'd6:    r = 8'd36;
            4'd7:    r = 8'd49;
            4'd8:    r = 8'd64;
            4'd9:    r = 8'd81;
            4'd10:   r = 8'd100;
            4'd11:   r = 8'd121;
            4'd12:   r = 8'd144;
            4'd13:   r = 8'd169;
            4'd14:   r = 8'd196;
            default: r = 8'd225;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/nibble_square.sv
// Combinational 4-bit squarer backed by the shared lookup table.
module nibble_square
    import sq_pkg::*;
(
    input  logic [SQ_NIB_W-1:0] i_nib,
    output logic [SQ_NSQ_W-1:0] o_sq
);

    assign o_sq = nib_sq(i_nib);

endmodule

// File: rtl/signed_8b_square.sv
// Registered exact square of a signed 8-bit sample, built from
// nibble tables and a 4x4 cross product instead of a full multiplier.
module signed_8b_square
    import sq_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [SQ_IN_W-1:0]  in_i,
    output logic [SQ_OUT_W-1:0] out_o
);

    logic [SQ_IN_W-1:0]  w_abs;
    logic [SQ_NIB_W-1:0] w_h;
    logic [SQ_NIB_W-1:0] w_l;
    logic [SQ_NSQ_W-1:0] w_h2;
    logic [SQ_NSQ_W-1:0] w_l2;
    logic [SQ_NSQ_W-1:0] w_hl;
    logic [SQ_OUT_W-1:0] w_hi;
    logic [SQ_OUT_W-1:0] w_mid;
    logic [SQ_OUT_W-1:0] w_lo;
    logic [SQ_OUT_W-1:0] w_sum;
    logic [SQ_OUT_W-1:0] r_out;

    // -128 wraps to 8'h80, which is exactly 128 as unsigned
    assign w_abs = in_i[SQ_IN_W-1] ? (~in_i + 8'd1) : in_i;
    assign w_h   = w_abs[7:4];
    assign w_l   = w_abs[3:0];

    nibble_square u_sq_hi (
        .i_nib (w_h),
        .o_sq  (w_h2)
    );

    nibble_square u_sq_lo (
        .i_nib (w_l),
        .o_sq  (w_l2)
    );

    assign w_hl = {4'b0000, w_h} * {4'b0000, w_l};

    // h never exceeds 8, so h^2 <= 64 and 256*h^2 fits in 15 bits
    assign w_hi  = SQ_OUT_W'({w_h2, 8'h00});
    assign w_mid = SQ_OUT_W'({w_hl, 5'b00000});
    assign w_lo  = SQ_OUT_W'(w_l2);
    assign w_sum = w_hi + w_mid + w_lo;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out <= '0;
        end else begin
            r_out <= w_sum;
        end
    end

    assign out_o = r_out;

endmodule

// File: tb/tb_signed_8b_square.sv
// Directed and sweep checks of signed_8b_square against a queued square model.
module tb_signed_8b_square;

    logic        clk_i;
    logic        rst_i;
    logic [7:0]  in_i;
    logic [14:0] out_o;

    logic [14:0] q_exp[$];
    string       q_tag[$];
    int          n_total;
    int          n_pass;

    signed_8b_square dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .in_i  (in_i),
        .out_o (out_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [14:0] ref_sq(input logic [7:0] v);
        int s;
        s = int'($signed(v));
        return 15'(s * s);
    endfunction

    task automatic check(input string tag, input logic [14:0] exp);
        n_total++;
        assert (out_o === exp) n_pass++;
        else $error("FAIL %s: out_o=%0d expected %0d", tag, out_o, exp);
    endtask

    task automatic pop_check();
        logic [14:0] e;
        string       t;
        e = q_exp.pop_front();
        t = q_tag.pop_front();
        check(t, e);
    endtask

    // Edge captures the previous value; new value goes in 1 ns later.
    task automatic drive(input logic [7:0] v, input string tag);
        @(posedge clk_i);
        #1;
        in_i = v;
        q_exp.push_back(ref_sq(v));
        q_tag.push_back(tag);
        @(negedge clk_i);
        if (q_exp.size() > 1) pop_check();
    endtask

    task automatic flush();
        @(posedge clk_i);
        @(negedge clk_i);
        n_total++;
        assert (q_exp.size() == 1) n_pass++;
        else $error("FAIL flush: queue depth=%0d expected %0d", q_exp.size(), 1);
        while (q_exp.size() > 0) pop_check();
    endtask

    task automatic mid_reset();
        @(posedge clk_i);
        #1;
        in_i = 8'd100;
        q_exp.delete();
        q_tag.delete();
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_async_drop", 15'd0);
        @(negedge clk_i);
        check("rst_mid_neg", 15'd0);
        @(posedge clk_i);
        #1;
        check("rst_mid_edge", 15'd0);
        @(negedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        check("rst_release_hold", 15'd0);
        q_exp.push_back(15'd10000);
        q_tag.push_back("rst_resume_100");
    endtask

    initial begin
        #2_000_000;
        $error("FAIL watchdog: time=%0t expected finish", $time);
        $fatal(1);
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_i   = 1'b1;
        in_i    = 8'hFB;
        #1;
        check("rst_t1", 15'd0);
        repeat (2) begin
            @(posedge clk_i);
            #1;
            check("rst_post_edge", 15'd0);
            @(negedge clk_i);
            check("rst_neg", 15'd0);
        end
        #1;
        rst_i = 1'b0;
        #1;
        check("rst_release", 15'd0);

        drive(8'd0,   "zero");
        drive(8'hFF,  "m1");
        drive(8'd1,   "p1");
        drive(8'h80,  "m128");
        drive(8'd127, "p127");
        drive(8'h81,  "m127");
        drive(8'd16,  "p16");
        drive(8'hEF,  "m17");
        drive(8'd15,  "p15");
        drive(8'h8F,  "m113");
        flush();

        n_total++;
        assert (ref_sq(8'h80) === 15'h4000 && ref_sq(8'h8F) === 15'd12769) n_pass++;
        else $error("FAIL model: m128=%0d expected %0d", ref_sq(8'h80), 16384);

        for (int i = -128; i <= 127; i++) begin
            if (i == 20) mid_reset();
            drive(8'(i), "sweep");
        end
        flush();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
